// File: rtl/iq_symbol_serializer.sv
// rtl/iq_symbol_serializer.sv - I/Q symbol to serial bitstream serialiser with hold/shift double buffer
// Build macro IQ_SER_GRAY_DECODE_EN: Gray-to-binary decode of each rail at capture.
module iq_symbol_serializer #(
    parameter int RAIL_W  = 2,
    parameter bit Q_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_clk_en,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic [RAIL_W-1:0] sym_I,
    input  logic [RAIL_W-1:0] sym_Q,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_sym_start,
    output logic              underrun
);
    localparam int SYMBOL_W = 2 * RAIL_W;
    localparam int CNT_W = $clog2(SYMBOL_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYMBOL_W - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    state_t state, state_next;

    logic [RAIL_W-1:0]   rail_i, rail_q;
    logic [SYMBOL_W-1:0] in_word, hold_word, shift_word;
    logic [CNT_W-1:0]    bit_cnt;
    logic                hold_full, underrun_pend;
    logic                accept, strobe, last_bit;
    logic                bypass, load_hold, load_shift, to_hold, starve;

`ifdef IQ_SER_GRAY_DECODE_EN
    // bin[k] = XOR of gray[RAIL_W-1:k], i.e. XOR of every right shift of the code
    function automatic logic [RAIL_W-1:0] gray2bin(input logic [RAIL_W-1:0] g);
        logic [RAIL_W-1:0] b;
        b = g;
        for (int s = 1; s < RAIL_W; s++) b = b ^ (g >> s);
        return b;
    endfunction
    assign rail_i = gray2bin(sym_I);
    assign rail_q = gray2bin(sym_Q);
`else
    assign rail_i = sym_I;
    assign rail_q = sym_Q;
`endif

    assign in_word   = Q_FIRST ? {rail_q, rail_i} : {rail_i, rail_q};
    assign sym_ready = ~hold_full;
    assign accept    = sym_valid & sym_ready;
    assign strobe    = (state == SHIFT) & bit_clk_en;
    assign last_bit  = strobe & (bit_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_shift) state_next = SHIFT;
            SHIFT:   if (starve) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift reg refills only when empty (IDLE) or draining its last bit this cycle
    always_comb begin
        load_hold  = hold_full & ((state == IDLE) | last_bit);
        bypass     = accept & ((state == IDLE) | last_bit);
        to_hold    = accept & ~bypass;
        load_shift = load_hold | bypass;
        starve     = last_bit & ~load_shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_word     <= '0;
            hold_full     <= 1'b0;
            shift_word    <= '0;
            bit_cnt       <= '0;
            ser_bit       <= 1'b0;
            ser_valid     <= 1'b0;
            ser_sym_start <= 1'b0;
            underrun_pend <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            ser_valid     <= strobe;
            ser_sym_start <= strobe & (bit_cnt == '0);
            underrun_pend <= starve;
            underrun      <= underrun_pend;
            if (strobe) begin
                ser_bit <= shift_word[SYMBOL_W-1];
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end
            if (load_shift)  shift_word <= load_hold ? hold_word : in_word;
            else if (strobe) shift_word <= shift_word << 1;
            if (to_hold) begin
                hold_word <= in_word;
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iq_symbol_serializer.sv
// tb/tb_iq_symbol_serializer.sv - directed self-checking bench for iq_symbol_serializer
module tb_iq_symbol_serializer;
    logic       clk = 1'b0;
    logic       reset;
    logic       bit_clk_en;
    logic       sym_valid, sym_ready;
    logic [1:0] sym_I, sym_Q;
    logic       ser_bit, ser_valid, ser_sym_start, underrun;
    logic       b_sym_valid, b_sym_ready;
    logic [2:0] b_sym_I, b_sym_Q;
    logic       b_ser_bit, b_ser_valid, b_ser_sym_start, b_underrun;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobe_period = 1;
    bit chk_hold = 1'b0;
    logic prev_bit;
    logic [63:0] a_vec, a_svec, b_vec, b_svec;
    int a_nb, a_nu, a_ucyc, b_nb, b_nu, b_ucyc;
    int a_vcyc[16];
    int b_vcyc[16];
    int acc, k;
    logic rdy;
    logic [1:0] s_i[3];
    logic [1:0] s_q[3];

    iq_symbol_serializer #(.RAIL_W(2), .Q_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bit_clk_en(bit_clk_en),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_I(sym_I), .sym_Q(sym_Q),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_sym_start(ser_sym_start), .underrun(underrun)
    );

    iq_symbol_serializer #(.RAIL_W(3), .Q_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bit_clk_en(bit_clk_en),
        .sym_valid(b_sym_valid), .sym_ready(b_sym_ready), .sym_I(b_sym_I), .sym_Q(b_sym_Q),
        .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .ser_sym_start(b_ser_sym_start), .underrun(b_underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] w2(input logic [1:0] i, input logic [1:0] q);
`ifdef IQ_SER_GRAY_DECODE_EN
        return {q[1], q[1] ^ q[0], i[1], i[1] ^ i[0]};
`else
        return {q, i};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        a_vec = '0; a_svec = '0; a_nb = 0; a_nu = 0; a_ucyc = -1;
        b_vec = '0; b_svec = '0; b_nb = 0; b_nu = 0; b_ucyc = -1;
        prev_bit = ser_bit;
    endtask

    task automatic tick();
        bit_clk_en = ((cyc % strobe_period) == 0);
        @(posedge clk);
        #1;
        cyc++;
        if (ser_valid) begin
            a_vec  = {a_vec[62:0], ser_bit};
            a_svec = {a_svec[62:0], ser_sym_start};
            if (a_nb < 16) a_vcyc[a_nb] = cyc;
            a_nb++;
        end
        if (underrun) begin a_nu++; a_ucyc = cyc; end
        if (chk_hold && !ser_valid) check("t3_hold_stable", 32'(ser_bit), 32'(prev_bit));
        prev_bit = ser_bit;
        if (b_ser_valid) begin
            b_vec  = {b_vec[62:0], b_ser_bit};
            b_svec = {b_svec[62:0], b_ser_sym_start};
            if (b_nb < 16) b_vcyc[b_nb] = cyc;
            b_nb++;
        end
        if (b_underrun) begin b_nu++; b_ucyc = cyc; end
    endtask

    initial begin
        reset = 1'b0; bit_clk_en = 1'b0;
        sym_valid = 1'b0; sym_I = '0; sym_Q = '0;
        b_sym_valid = 1'b0; b_sym_I = '0; b_sym_Q = '0;
        s_i[0] = 2'b11; s_q[0] = 2'b00;
        s_i[1] = 2'b01; s_q[1] = 2'b10;
        s_i[2] = 2'b00; s_q[2] = 2'b11;
        clear_mon();

        // reset state and idle strobes
        repeat (3) tick();
        check("rst_outputs", 32'({ser_bit, ser_valid, ser_sym_start, underrun}), 32'd0);
        reset = 1'b1;
        clear_mon();
        repeat (3) tick();
        check("rst_sym_ready", 32'(sym_ready), 32'd1);
        check("idle_no_valid", 32'(a_nb + b_nb), 32'd0);

        // test 1: single symbol I=10 Q=01, strobe every clk
        clear_mon();
        sym_I = 2'b10; sym_Q = 2'b01; sym_valid = 1'b1;
        tick();
        acc = cyc;
        sym_valid = 1'b0;
        repeat (8) tick();
        check("t1_nbits", 32'(a_nb), 32'd4);
        check("t1_bits", a_vec[31:0], 32'(w2(2'b10, 2'b01)));
        check("t1_starts", a_svec[31:0], 32'h8);
        check("t1_latency", 32'(a_vcyc[0]), 32'(acc + 1));
        check("t1_underrun_cnt", 32'(a_nu), 32'd1);
        check("t1_underrun_cyc", 32'(a_ucyc), 32'(a_vcyc[3] + 1));

        // test 2: three back-to-back symbols, valid held high
        clear_mon();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            rdy = sym_ready;
            sym_valid = (k < 3);
            sym_I = s_i[k % 3]; sym_Q = s_q[k % 3];
            tick();
            if (sym_valid && rdy) begin
                k++;
                if (k == 2) check("t2_ready_low_hold_full", 32'(sym_ready), 32'd0);
            end
        end
        sym_valid = 1'b0;
        check("t2_accepted", 32'(k), 32'd3);
        check("t2_nbits", 32'(a_nb), 32'd12);
        check("t2_bits", a_vec[31:0], 32'({w2(s_i[0], s_q[0]), w2(s_i[1], s_q[1]), w2(s_i[2], s_q[2])}));
        check("t2_starts", a_svec[31:0], 32'h888);
        check("t2_gapless", 32'(a_vcyc[11] - a_vcyc[0]), 32'd11);
        check("t2_underrun_cnt", 32'(a_nu), 32'd1);
        check("t2_underrun_cyc", 32'(a_ucyc), 32'(a_vcyc[11] + 1));

        // test 3: strobe every 4th clk
        strobe_period = 4;
        clear_mon();
        chk_hold = 1'b1;
        sym_I = 2'b10; sym_Q = 2'b01; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        repeat (30) tick();
        chk_hold = 1'b0;
        strobe_period = 1;
        check("t3_nbits", 32'(a_nb), 32'd4);
        check("t3_bits", a_vec[31:0], 32'(w2(2'b10, 2'b01)));
        for (int i = 0; i < 3; i++) check("t3_spacing", 32'(a_vcyc[i+1] - a_vcyc[i]), 32'd4);
        check("t3_underrun_cnt", 32'(a_nu), 32'd1);

        // test 4: async reset mid-symbol with hold full
        clear_mon();
        sym_I = 2'b10; sym_Q = 2'b01; sym_valid = 1'b1;
        tick();
        sym_I = 2'b11; sym_Q = 2'b11;
        tick();
        tick();
        check("t4_pre_nbits", 32'(a_nb), 32'd2);
        check("t4_pre_bit", 32'({ser_bit, ser_valid, sym_ready}), 32'b110);
        sym_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t4_async_outputs", 32'({ser_bit, ser_valid, ser_sym_start, underrun}), 32'd0);
        check("t4_async_ready", 32'(sym_ready), 32'd1);
        tick();
        reset = 1'b1;
        clear_mon();
        sym_I = 2'b01; sym_Q = 2'b10; sym_valid = 1'b1;
        tick();
        acc = cyc;
        sym_valid = 1'b0;
        repeat (8) tick();
        check("t4_post_nbits", 32'(a_nb), 32'd4);
        check("t4_post_bits", a_vec[31:0], 32'(w2(2'b01, 2'b10)));
        check("t4_post_starts", a_svec[31:0], 32'h8);
        check("t4_post_latency", 32'(a_vcyc[0]), 32'(acc + 1));

        // test 5: I=Q=11, result depends on Gray decode build
        clear_mon();
        sym_I = 2'b11; sym_Q = 2'b11; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        repeat (8) tick();
        check("t5_nbits", 32'(a_nb), 32'd4);
`ifdef IQ_SER_GRAY_DECODE_EN
        check("t5_bits", a_vec[31:0], 32'b1010);
`else
        check("t5_bits", a_vec[31:0], 32'b1111);
`endif

        // test 6: RAIL_W=3, Q_FIRST=0, I=101 Q=011
        clear_mon();
        b_sym_I = 3'b101; b_sym_Q = 3'b011; b_sym_valid = 1'b1;
        tick();
        b_sym_valid = 1'b0;
        repeat (10) tick();
        check("t6_nbits", 32'(b_nb), 32'd6);
`ifdef IQ_SER_GRAY_DECODE_EN
        check("t6_bits", b_vec[31:0], 32'b110010);
`else
        check("t6_bits", b_vec[31:0], 32'b101011);
`endif
        check("t6_starts", b_svec[31:0], 32'b100000);
        check("t6_underrun_cnt", 32'(b_nu), 32'd1);
        check("t6_underrun_cyc", 32'(b_ucyc), 32'(b_vcyc[5] + 1));
        check("t6_a_quiet", 32'(a_nb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
